// File: rtl/semaforo_ctrl_if.sv
// Signal bundle between the crossing phase sequencer and its environment.
// Clock and reset stay plain ports on the sequencer.
interface semaforo_ctrl_if;
    logic       tick;
    logic       btn_peaton;
    logic [1:0] vehicular;
    logic [1:0] peatonal;
    logic       req_pend;
    logic [2:0] estado;

    modport master (
        output tick,
        output btn_peaton,
        input  vehicular,
        input  peatonal,
        input  req_pend,
        input  estado
    );

    modport slave (
        input  tick,
        input  btn_peaton,
        output vehicular,
        output peatonal,
        output req_pend,
        output estado
    );
endinterface

// File: rtl/semaforo_ctrl.sv
// Phase sequencer for a single pedestrian crossing: times vehicle and pedestrian
// phases on an external tick enable and serves latched pedestrian requests.
module semaforo_ctrl #(
    parameter int unsigned T_MIN_VERDE = 10,
    parameter int unsigned T_AMARILLO  = 3,
    parameter int unsigned T_ROJO      = 2,
    parameter int unsigned T_PEATON    = 8,
    parameter int unsigned T_PARPADEO  = 4,
    parameter int unsigned CW          = 8
) (
    input logic           clk,
    input logic           rst,
    semaforo_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StRojoIni  = 3'd0,
        StVehVerde = 3'd1,
        StVehAmar  = 3'd2,
        StRojoA    = 3'd3,
        StPeaVerde = 3'd4,
        StPeaParp  = 3'd5,
        StRojoB    = 3'd6
    } state_e;

    localparam logic [CW-1:0] LimVerde = CW'(T_MIN_VERDE - 1);
    localparam logic [CW-1:0] LimAmar  = CW'(T_AMARILLO - 1);
    localparam logic [CW-1:0] LimRojo  = CW'(T_ROJO - 1);
    localparam logic [CW-1:0] LimPea   = CW'(T_PEATON - 1);
    localparam logic [CW-1:0] LimParp  = CW'(T_PARPADEO - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    veh_q, veh_d;
    logic [1:0]    pea_q, pea_d;
    logic          req_pend_q, req_pend_d;
    logic [1:0]    sync_q;
    logic          btn_prev_q;
    logic          btn_edge;

    logic [CW-1:0] lim;
    state_e        nxt;
    logic          gate;
    logic          legal;
    logic          enter_pea;
    logic          serving;

    assign btn_edge = sync_q[1] & ~btn_prev_q;

    always_comb begin
        lim   = LimRojo;
        nxt   = StRojoIni;
        gate  = 1'b1;
        legal = 1'b1;
        unique case (state_q)
            StRojoIni:  begin lim = LimRojo;  nxt = StVehVerde; end
            // Green saturates at its minimum and leaves only once a request is pending.
            StVehVerde: begin lim = LimVerde; nxt = StVehAmar; gate = req_pend_q; end
            StVehAmar:  begin lim = LimAmar;  nxt = StRojoA;    end
            StRojoA:    begin lim = LimRojo;  nxt = StPeaVerde; end
            StPeaVerde: begin lim = LimPea;   nxt = StPeaParp;  end
            StPeaParp:  begin lim = LimParp;  nxt = StRojoB;    end
            StRojoB:    begin lim = LimRojo;  nxt = StVehVerde; end
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!legal) begin
            state_d = StRojoIni;
        end else if (bus.tick) begin
            if (cnt_q == lim) begin
                if (gate) state_d = nxt;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        veh_d = 2'b10;
        pea_d = 2'b10;
        unique case (state_d)
            StVehVerde: veh_d = 2'b00;
            StVehAmar:  veh_d = 2'b01;
            StPeaVerde: pea_d = 2'b00;
            StPeaParp:  pea_d = 2'b01;
            default:    ;
        endcase
    end

    // Entering pedestrian green clears the request even if an edge lands in the same cycle.
    always_comb begin
        enter_pea  = (state_d == StPeaVerde) && (state_q != StPeaVerde);
        serving    = (state_q == StPeaVerde) || (state_q == StPeaParp);
        req_pend_d = req_pend_q | (btn_edge & ~serving);
        if (enter_pea) req_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRojoIni;
            cnt_q      <= '0;
            veh_q      <= 2'b10;
            pea_q      <= 2'b10;
            req_pend_q <= 1'b0;
            sync_q     <= 2'b00;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            veh_q      <= veh_d;
            pea_q      <= pea_d;
            req_pend_q <= req_pend_d;
            sync_q     <= {sync_q[0], bus.btn_peaton};
            btn_prev_q <= sync_q[1];
        end
    end

    assign bus.vehicular = veh_q;
    assign bus.peatonal  = pea_q;
    assign bus.req_pend  = req_pend_q;
    assign bus.estado    = state_q;

endmodule
